// File: rtl/fifo_ram_pkg.sv
// fifo_ram_pkg: shared state encoding, read-during-write constants and lane helper for the banked FIFO RAM
package fifo_ram_pkg;
  typedef enum logic {ST_INIT, ST_READY} ram_state_e;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  function automatic int lane_count(input int dw, input int lw);
    return dw / lw;
  endfunction
endpackage

// File: rtl/fifo_ram_init_seq.sv
// fifo_ram_init_seq: post-reset sequencer that sweeps zeros through the array before user access
module fifo_ram_init_seq import fifo_ram_pkg::*; #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  g_clk,
  input  logic                  w_rst,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_done
);
  ram_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic last;
  always_comb begin
    last    = state_q == ST_INIT && cnt_q == ADDR_WIDTH'(DEPTH - 1);
    state_d = last ? ST_READY : state_q;
    cnt_d   = (state_q == ST_INIT && !last) ? cnt_q + 1'b1 : cnt_q;
    done_d  = done_q | last;
  end
  always_ff @(posedge g_clk or negedge w_rst)
    if (!w_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  assign clr_en    = state_q == ST_INIT;
  assign clr_addr  = cnt_q;
  assign init_done = done_q;
endmodule

// File: rtl/fifo_ram_banked.sv
// fifo_ram_banked: lane-masked single-clock FIFO storage RAM with 1/2-cycle read pipeline
// and configurable read-during-write; cleared by a sequencer so it maps onto RAM macros.
module fifo_ram_banked import fifo_ram_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                                            g_clk,
  input  logic                                            w_rst,
  input  logic                                            wclken,
  input  logic [lane_count(DATA_WIDTH, LANE_WIDTH)-1:0]   wmask,
  input  logic [ADDR_WIDTH-1:0]                           waddr,
  input  logic [DATA_WIDTH-1:0]                           wdata,
  input  logic                                            rden,
  input  logic [ADDR_WIDTH-1:0]                           raddr,
  output logic [DATA_WIDTH-1:0]                           rdata,
  output logic                                            rvalid,
  output logic                                            init_done
);
  localparam int LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
    $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("RD_LATENCY must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must be within 1..2**ADDR_WIDTH");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  fifo_ram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_init (
    .g_clk(g_clk), .w_rst(w_rst), .clr_en(clr_en), .clr_addr(clr_addr), .init_done(init_done)
  );
  logic user_wr, we, rd_fire, rd_hit;
  logic [ADDR_WIDTH-1:0] wa;
  logic [LANES-1:0] wm;
  logic [DATA_WIDTH-1:0] wd, rd_old, rd_new, rword;
  logic p_valid_q, p_valid_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d, rdata_q, rdata_d;
  always_comb begin
    user_wr = init_done && wclken && int'(waddr) < DEPTH;
    we      = clr_en | user_wr;
    wa      = clr_en ? clr_addr : waddr;
    wm      = clr_en ? '1 : wmask;
    wd      = clr_en ? '0 : wdata;
    rd_fire = init_done && rden;
    rd_hit  = int'(raddr) < DEPTH;
    rd_old  = rd_hit ? mem[raddr] : '0;
    rd_new  = rd_old;
    // new-data bypass: overlay the lanes being written this edge onto the stored word
    for (int i = 0; i < LANES; i++)
      if (user_wr && waddr == raddr && wmask[i])
        rd_new[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
    rword     = RDW_MODE == RDW_NEW ? rd_new : rd_old;
    p_valid_d = rd_fire;
    p_data_d  = rd_fire ? rword : p_data_q;
    rvalid_d  = RD_LATENCY == 2 ? p_valid_q : rd_fire;
    rdata_d   = RD_LATENCY == 2 ? (p_valid_q ? p_data_q : rdata_q) : (rd_fire ? rword : rdata_q);
  end
  always_ff @(posedge g_clk)
    if (we)
      for (int i = 0; i < LANES; i++)
        if (wm[i]) mem[wa][i*LANE_WIDTH +: LANE_WIDTH] <= wd[i*LANE_WIDTH +: LANE_WIDTH];
  always_ff @(posedge g_clk or negedge w_rst)
    if (!w_rst) begin
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_data_q  <= p_data_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
endmodule

// File: tb/tb_fifo_ram_banked.sv
// tb_fifo_ram_banked: two configurations driven in lockstep, checked against a queue scoreboard
module tb_fifo_ram_banked;
  localparam int DA = 12, LA = 1;
  localparam int DB = 16, LB = 2;
  typedef struct { logic [31:0] d; int due; } exp_t;
  logic g_clk = 1'b0, w_rst = 1'b1;
  logic wclken = 1'b0, rden = 1'b0;
  logic [3:0] wmask = '0, waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_a, rdata_b;
  logic rvalid_a, rvalid_b, init_done_a, init_done_b;
  logic [31:0] ma [16], mb [16];
  exp_t qa[$], qb[$];
  int errs = 0, checks = 0, cyc = 0, since = 0;

  fifo_ram_banked #(.DATA_WIDTH(32), .LANE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(DA), .RD_LATENCY(LA), .RDW_MODE(0)) u_a (
    .g_clk(g_clk), .w_rst(w_rst), .wclken(wclken), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .rden(rden), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .init_done(init_done_a));
  fifo_ram_banked #(.DATA_WIDTH(32), .LANE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(DB), .RD_LATENCY(LB), .RDW_MODE(1)) u_b (
    .g_clk(g_clk), .w_rst(w_rst), .wclken(wclken), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .rden(rden), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .init_done(init_done_b));

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    merge = o;
    for (int i = 0; i < 4; i++) if (m[i]) merge[i*8 +: 8] = n[i*8 +: 8];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
    qa.delete();
    qb.delete();
  endtask

  task automatic step(input logic we, input logic [3:0] m, input logic [3:0] wa, input logic [31:0] wd,
                      input logic re, input logic [3:0] ra);
    exp_t e;
    wclken = we; wmask = m; waddr = wa; wdata = wd; rden = re; raddr = ra;
    if (since >= DA) begin
      if (re) begin e.d = int'(ra) < DA ? ma[ra] : '0; e.due = cyc + LA; qa.push_back(e); end
      if (we && int'(wa) < DA) ma[wa] = merge(ma[wa], wd, m);
    end
    if (since >= DB) begin
      if (re) begin
        e.d = int'(ra) < DB ? ((we && wa == ra) ? merge(mb[ra], wd, m) : mb[ra]) : '0;
        e.due = cyc + LB;
        qb.push_back(e);
      end
      if (we && int'(wa) < DB) mb[wa] = merge(mb[wa], wd, m);
    end
    @(posedge g_clk); #1;
    since++;
    chk("init_done_a", 32'(init_done_a), 32'(since >= DA));
    chk("init_done_b", 32'(init_done_b), 32'(since >= DB));
  endtask

  always @(negedge g_clk) begin
    if (qa.size() != 0 && qa[0].due == cyc) begin
      chk("rvalid_a", 32'(rvalid_a), 32'd1);
      chk("rdata_a", rdata_a, qa[0].d);
      void'(qa.pop_front());
    end else chk("idle_rvalid_a", 32'(rvalid_a), 32'd0);
  end
  always @(negedge g_clk) begin
    if (qb.size() != 0 && qb[0].due == cyc) begin
      chk("rvalid_b", 32'(rvalid_b), 32'd1);
      chk("rdata_b", rdata_b, qb[0].d);
      void'(qb.pop_front());
    end else chk("idle_rvalid_b", 32'(rvalid_b), 32'd0);
  end

  initial begin
    model_clear();
    #3 w_rst = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);
    chk("rst_done_a", 32'(init_done_a), 32'd0);
    chk("rst_done_b", 32'(init_done_b), 32'd0);
    w_rst = 1'b1;
    since = 0;
    repeat (18) step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    step(1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0);
    step(1'b1, 4'h5, 4'd5, 32'h11223344, 1'b0, 4'd0);
    step(1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);
    for (int i = 1; i <= 3; i++) step(1'b1, 4'hF, 4'(i), 32'(i), 1'b0, 4'd0);
    for (int i = 1; i <= 3; i++) step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(i));
    step(1'b1, 4'hF, 4'd7, 32'h55, 1'b0, 4'd0);
    step(1'b1, 4'hF, 4'd7, 32'h99, 1'b1, 4'd7);
    step(1'b1, 4'h1, 4'd7, 32'hAA, 1'b1, 4'd7);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7);
    step(1'b1, 4'hF, 4'd13, 32'hFF, 1'b0, 4'd0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd13);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd15);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd11);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0);
    step(1'b1, 4'hF, 4'd2, 32'hEE, 1'b0, 4'd0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
    w_rst = 1'b0;
    model_clear();
    since = 0;
    #1;
    chk("mid_rst_rvalid_a", 32'(rvalid_a), 32'd0);
    chk("mid_rst_rvalid_b", 32'(rvalid_b), 32'd0);
    chk("mid_rst_rdata_a", rdata_a, 32'd0);
    chk("mid_rst_rdata_b", rdata_b, 32'd0);
    @(posedge g_clk); #1;
    w_rst = 1'b1;
    repeat (18) step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
    repeat (4) step(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("drained_a", 32'(qa.size()), 32'd0);
    chk("drained_b", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
